// File: rtl/satswarmv2_pkg.sv
// Shared types for the SAT-swarm grid: NoC packet layout, message classes and
// the virtual-channel assignment used by every core's injection path.
package satswarmv2_pkg;

   localparam int CORE_ID_W = 8;
   localparam int LBD_W     = 8;
   localparam int VC_W      = 2;
   localparam int PAYLOAD_W = 64;

   typedef enum logic [2:0] {
      MSG_DIVERGE  = 3'd0,
      MSG_CLAUSE   = 3'd1,
      MSG_STATUS   = 3'd2,
      MSG_RESERVED = 3'd7
   } msg_type_t;

   typedef struct packed {
      msg_type_t              msg_type;
      logic [CORE_ID_W-1:0]   src_id;
      logic [VC_W-1:0]        virtual_channel;
      logic [LBD_W-1:0]       quality_metric;
      logic [PAYLOAD_W-1:0]   payload;
   } noc_packet_t;

   typedef enum logic [1:0] {
      CLS_DIV    = 2'd0,
      CLS_CLAUSE = 2'd1,
      CLS_STATUS = 2'd2
   } msg_class_t;

   localparam int VC_DIVERGE = 0;
   localparam int VC_CLAUSE  = 1;
   localparam int VC_STATUS  = 2;

   typedef logic [3:0] status_code_t;

   // Round-robin successor, wrapping STATUS back to DIV.
   function automatic msg_class_t nextClass(input msg_class_t c);
      case (c)
         CLS_DIV:    return CLS_CLAUSE;
         CLS_CLAUSE: return CLS_STATUS;
         default:    return CLS_DIV;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter over the message classes; the pointer names the
// class that has first claim on the next grant.
module rr_arbiter3
   import satswarmv2_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_enable,
   input  logic [2:0] i_elig,
   output logic [2:0] o_grant
);

   msg_class_t r_ptr;
   msg_class_t w_ptrNext;
   msg_class_t w_first;
   msg_class_t w_second;
   msg_class_t w_third;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= CLS_DIV;
      end else begin
         r_ptr <= w_ptrNext;
      end
   end

   // The pointer only advances past a winner; idle cycles leave it in place.
   always_comb begin
      w_first   = r_ptr;
      w_second  = nextClass(r_ptr);
      w_third   = nextClass(w_second);
      o_grant   = '0;
      w_ptrNext = r_ptr;
      if (i_enable) begin
         if (i_elig[w_first]) begin
            o_grant[w_first] = 1'b1;
            w_ptrNext        = nextClass(w_first);
         end else if (i_elig[w_second]) begin
            o_grant[w_second] = 1'b1;
            w_ptrNext         = nextClass(w_second);
         end else if (i_elig[w_third]) begin
            o_grant[w_third] = 1'b1;
            w_ptrNext        = nextClass(w_third);
         end
      end
   end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Per-core NoC injection scheduler: arbitrates divergence, clause-share and status
// messages onto one router port with per-VC credit flow control.
module noc_inject_arbiter
   import satswarmv2_pkg::*;
#(
   parameter int CORE_ID    = 0,
   parameter int CREDITS    = 4,
   parameter int LBD_THRESH = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              div_valid,
   input  logic [31:0]       div_lit,
   output logic              div_ready,
   input  logic              cls_valid,
   input  logic [31:0]       cls_lit0,
   input  logic [31:0]       cls_lit1,
   input  logic [LBD_W-1:0]  cls_lbd,
   output logic              cls_ready,
   input  logic              sts_valid,
   input  status_code_t      sts_code,
   output logic              sts_ready,
   input  logic [3:0]        credit_ret,
   output logic              pkt_valid,
   output noc_packet_t       pkt_out,
   output logic [15:0]       drop_cnt,
   output logic              credit_err
);

   localparam logic [3:0]       CRED_MAX  = 4'(CREDITS);
   localparam logic [LBD_W-1:0] LBD_LIMIT = LBD_W'(LBD_THRESH);

   logic [3:0]   r_cred [3];
   logic         r_pktValid;
   noc_packet_t  r_pkt;
   logic [15:0]  r_dropCnt;
   logic         r_creditErr;

   logic [2:0]   w_elig;
   logic [2:0]   w_grant;
   logic         w_drop;
   noc_packet_t  w_pkt;
   logic         w_unusedRet;

   // VC3 has no traffic class, so its return bit carries no meaning here.
   assign w_unusedRet = credit_ret[3];

   assign w_elig[VC_DIVERGE] = div_valid && (r_cred[VC_DIVERGE] != 4'd0);
   assign w_elig[VC_CLAUSE]  = cls_valid && (cls_lbd <= LBD_LIMIT) && (r_cred[VC_CLAUSE] != 4'd0);
   assign w_elig[VC_STATUS]  = sts_valid && (r_cred[VC_STATUS] != 4'd0);
   assign w_drop             = enable && cls_valid && (cls_lbd > LBD_LIMIT);

   rr_arbiter3 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (enable),
      .i_elig   (w_elig),
      .o_grant  (w_grant)
   );

   assign div_ready  = w_grant[CLS_DIV];
   assign cls_ready  = w_grant[CLS_CLAUSE] | w_drop;
   assign sts_ready  = w_grant[CLS_STATUS];
   assign pkt_valid  = r_pktValid;
   assign pkt_out    = r_pkt;
   assign drop_cnt   = r_dropCnt;
   assign credit_err = r_creditErr;

   // Format the packet for whichever class won; DIV is the fallback encoding.
   always_comb begin
      w_pkt        = '0;
      w_pkt.src_id = CORE_ID_W'(CORE_ID);
      if (w_grant[CLS_CLAUSE]) begin
         w_pkt.msg_type        = MSG_CLAUSE;
         w_pkt.virtual_channel = VC_W'(VC_CLAUSE);
         w_pkt.quality_metric  = cls_lbd;
         w_pkt.payload         = {cls_lit1, cls_lit0};
      end else if (w_grant[CLS_STATUS]) begin
         w_pkt.msg_type        = MSG_STATUS;
         w_pkt.virtual_channel = VC_W'(VC_STATUS);
         w_pkt.payload         = {60'b0, sts_code};
      end else begin
         w_pkt.msg_type        = MSG_DIVERGE;
         w_pkt.virtual_channel = VC_W'(VC_DIVERGE);
         w_pkt.payload         = {32'b0, div_lit};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pktValid <= 1'b0;
         r_pkt      <= '0;
      end else begin
         r_pktValid <= |w_grant;
         if (|w_grant) begin
            r_pkt <= w_pkt;
         end
      end
   end

   // A grant and a return on the same VC cancel; a return at full credit is an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < 3; v++) begin
            r_cred[v] <= CRED_MAX;
         end
         r_creditErr <= 1'b0;
      end else begin
         for (int v = 0; v < 3; v++) begin
            if (credit_ret[v] && !w_grant[v]) begin
               if (r_cred[v] == CRED_MAX) begin
                  r_creditErr <= 1'b1;
               end else begin
                  r_cred[v] <= r_cred[v] + 4'd1;
               end
            end else if (w_grant[v] && !credit_ret[v]) begin
               r_cred[v] <= r_cred[v] - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dropCnt <= '0;
      end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
         r_dropCnt <= r_dropCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a queue-free behavioural model.
module tb_noc_inject_arbiter;
   import satswarmv2_pkg::*;

   localparam int CORE_ID    = 5;
   localparam int CREDITS    = 4;
   localparam int LBD_THRESH = 6;

   logic             clk;
   logic             rst_n;
   logic             enable;
   logic             div_valid;
   logic [31:0]      div_lit;
   logic             div_ready;
   logic             cls_valid;
   logic [31:0]      cls_lit0;
   logic [31:0]      cls_lit1;
   logic [LBD_W-1:0] cls_lbd;
   logic             cls_ready;
   logic             sts_valid;
   status_code_t     sts_code;
   logic             sts_ready;
   logic [3:0]       credit_ret;
   logic             pkt_valid;
   noc_packet_t      pkt_out;
   logic [15:0]      drop_cnt;
   logic             credit_err;

   noc_inject_arbiter #(
      .CORE_ID    (CORE_ID),
      .CREDITS    (CREDITS),
      .LBD_THRESH (LBD_THRESH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .div_valid  (div_valid),
      .div_lit    (div_lit),
      .div_ready  (div_ready),
      .cls_valid  (cls_valid),
      .cls_lit0   (cls_lit0),
      .cls_lit1   (cls_lit1),
      .cls_lbd    (cls_lbd),
      .cls_ready  (cls_ready),
      .sts_valid  (sts_valid),
      .sts_code   (sts_code),
      .sts_ready  (sts_ready),
      .credit_ret (credit_ret),
      .pkt_valid  (pkt_valid),
      .pkt_out    (pkt_out),
      .drop_cnt   (drop_cnt),
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;

   // Model state: credits per VC, next class with priority, counters, last packet.
   int          mCred [3];
   int          mPtr;
   int          mDrop;
   bit          mErr;
   bit          mPv;
   noc_packet_t mPkt;
   int          mGrant;
   bit          mDropNow;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void modelReset();
      for (int v = 0; v < 3; v++) mCred[v] = CREDITS;
      mPtr  = 0;
      mDrop = 0;
      mErr  = 0;
      mPv   = 0;
      mPkt  = '0;
   endfunction

   function automatic void modelEval();
      bit el [3];
      el[0] = div_valid && (mCred[0] > 0);
      el[1] = cls_valid && (int'(cls_lbd) <= LBD_THRESH) && (mCred[1] > 0);
      el[2] = sts_valid && (mCred[2] > 0);
      mGrant = -1;
      if (enable) begin
         for (int k = 0; k < 3; k++) begin
            int c;
            c = (mPtr + k) % 3;
            if (mGrant < 0 && el[c]) mGrant = c;
         end
      end
      mDropNow = enable && cls_valid && (int'(cls_lbd) > LBD_THRESH);
   endfunction

   function automatic noc_packet_t buildPkt(input int g);
      noc_packet_t p;
      p                 = '0;
      p.src_id          = CORE_ID_W'(CORE_ID);
      p.virtual_channel = VC_W'(g);
      case (g)
         0: begin
            p.msg_type = MSG_DIVERGE;
            p.payload  = {32'b0, div_lit};
         end
         1: begin
            p.msg_type       = MSG_CLAUSE;
            p.payload        = {cls_lit1, cls_lit0};
            p.quality_metric = cls_lbd;
         end
         default: begin
            p.msg_type = MSG_STATUS;
            p.payload  = {60'b0, sts_code};
         end
      endcase
      return p;
   endfunction

   function automatic void modelUpdate();
      mPv = (mGrant >= 0);
      if (mGrant >= 0) begin
         mPkt = buildPkt(mGrant);
         mPtr = (mGrant + 1) % 3;
      end
      for (int v = 0; v < 3; v++) begin
         if (mGrant == v && credit_ret[v]) begin
         end else if (mGrant == v) begin
            mCred[v] = mCred[v] - 1;
         end else if (credit_ret[v]) begin
            if (mCred[v] == CREDITS) mErr = 1;
            else mCred[v] = mCred[v] + 1;
         end
      end
      if (mDropNow && mDrop < 65535) mDrop++;
   endfunction

   task automatic checkOutput();
      chk("div_ready", div_ready, mGrant == 0);
      chk("cls_ready", cls_ready, (mGrant == 1) || mDropNow);
      chk("sts_ready", sts_ready, mGrant == 2);
      chk("pkt_valid", pkt_valid, mPv);
      if (mPv) chk("pkt_out", pkt_out, mPkt);
      chk("drop_cnt", drop_cnt, mDrop);
      chk("credit_err", credit_err, mErr);
   endtask

   // Called at a falling edge with inputs already applied; returns at the next one.
   task automatic stepCycle();
      #1;
      modelEval();
      checkOutput();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit en, input bit dv, input logic [31:0] dl,
                                input bit cv, input logic [31:0] l0, input logic [31:0] l1,
                                input logic [LBD_W-1:0] lbd, input bit sv, input logic [3:0] sc,
                                input logic [3:0] ret);
      enable     = en;
      div_valid  = dv;
      div_lit    = dl;
      cls_valid  = cv;
      cls_lit0   = l0;
      cls_lit1   = l1;
      cls_lbd    = lbd;
      sts_valid  = sv;
      sts_code   = sc;
      credit_ret = ret;
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      rst_n = 1'b0;
      modelReset();
      #2;
      modelEval();
      checkOutput();
      chk("reset_pkt_out", pkt_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] seenOrder [12];
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      doReset();
      stepCycle();
      stepCycle();

      // Single divergence of literal -5.
      applyStimulus(1, 1, 32'hFFFF_FFFB, 0, 0, 0, 0, 0, 0, 4'b0000);
      #1 chk("div_single_ready", div_ready, 1);
      stepCycle();
      div_valid = 0;
      #1;
      chk("div_single_pv", pkt_valid, 1);
      chk("div_single_lit", pkt_out.payload, 64'h0000_0000_FFFF_FFFB);
      chk("div_single_type", pkt_out.msg_type, MSG_DIVERGE);
      chk("div_single_src", pkt_out.src_id, 8'd5);
      chk("div_single_vc", pkt_out.virtual_channel, 2'd0);
      stepCycle();

      // Everything valid, no returns: round-robin until all credits are spent.
      doReset();
      applyStimulus(1, 1, 32'd7, 1, 32'd11, 32'd12, 8'd3, 1, 4'h9, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         #1 seenOrder[i] = {sts_ready, cls_ready, div_ready};
         stepCycle();
      end
      for (int i = 0; i < 12; i++) chk("rr_order", seenOrder[i], 3'b001 << (i % 3));
      stepCycle();
      #1 chk("starved_ready", {sts_ready, cls_ready, div_ready}, 3'b000);
      stepCycle();
      credit_ret = 4'b0010;
      stepCycle();
      credit_ret = 4'b0000;
      #1 chk("cls_after_return", {sts_ready, cls_ready, div_ready}, 3'b010);
      stepCycle();
      stepCycle();
      #1 chk("cls_single_pkt_done", pkt_valid, 0);

      // High-LBD clause dropped alongside a divergence grant.
      doReset();
      applyStimulus(1, 1, 32'd3, 1, 32'hA, 32'hB, 8'd9, 0, 0, 4'b0000);
      #1 chk("drop_both_ready", {cls_ready, div_ready}, 2'b11);
      stepCycle();
      applyStimulus(1, 0, 0, 1, 32'h1234, 32'h5678, 8'd6, 0, 0, 4'b0000);
      #1;
      chk("drop_cnt_one", drop_cnt, 16'd1);
      chk("drop_pkt_type", pkt_out.msg_type, MSG_DIVERGE);
      chk("lbd_eq_ready", cls_ready, 1);
      stepCycle();
      cls_valid = 0;
      #1;
      chk("lbd_eq_qm", pkt_out.quality_metric, 8'd6);
      chk("lbd_eq_payload", pkt_out.payload, 64'h0000_5678_0000_1234);
      chk("lbd_eq_vc", pkt_out.virtual_channel, 2'd1);
      stepCycle();

      // VC0 exhausted, then refilled by one return.
      doReset();
      applyStimulus(1, 1, 32'd1, 0, 0, 0, 0, 0, 0, 4'b0000);
      for (int i = 0; i < 4; i++) stepCycle();
      credit_ret = 4'b0001;
      #1 chk("vc0_empty", div_ready, 0);
      stepCycle();
      credit_ret = 4'b0000;
      #1 chk("vc0_refilled", div_ready, 1);
      stepCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'h3, 4'b0100);
      for (int i = 0; i < 5; i++) stepCycle();
      #1;
      chk("vc2_cancel_ready", sts_ready, 1);
      chk("vc2_cancel_noerr", credit_err, 0);
      stepCycle();

      // Return at full credit raises a sticky error.
      doReset();
      credit_ret = 4'b0001;
      stepCycle();
      credit_ret = 4'b0000;
      #1 chk("credit_err_set", credit_err, 1);
      for (int i = 0; i < 3; i++) stepCycle();
      #1 chk("credit_err_sticky", credit_err, 1);
      stepCycle();

      // enable falls after a grant; then reset while a packet is out.
      doReset();
      applyStimulus(1, 1, 32'd9, 0, 0, 0, 0, 0, 0, 4'b0000);
      stepCycle();
      enable = 0;
      #1;
      chk("en_off_ready", div_ready, 0);
      chk("en_off_pkt", pkt_valid, 1);
      stepCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      #1 chk("en_off_no_more", pkt_valid, 0);
      div_valid = 1;
      stepCycle();
      div_valid = 0;
      #1 chk("pre_reset_pv", pkt_valid, 1);
      rst_n = 1'b0;
      #1 chk("reset_clears_pv", pkt_valid, 0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      div_valid = 1;
      for (int i = 0; i < 3; i++) stepCycle();
      #1 chk("credits_restored", div_ready, 1);
      stepCycle();

      // Randomized traffic honouring the hold-until-ready protocol.
      for (int seg = 0; seg < 4; seg++) begin
         doReset();
         for (int cyc = 0; cyc < 600; cyc++) begin
            logic [2:0] rdy;
            enable     = ($urandom_range(9) != 0);
            credit_ret = 4'($urandom_range(15) & $urandom_range(15));
            if (!div_valid && $urandom_range(2) == 0) begin
               div_valid = 1;
               div_lit   = $urandom;
            end
            if (!cls_valid && $urandom_range(2) == 0) begin
               cls_valid = 1;
               cls_lit0  = $urandom;
               cls_lit1  = $urandom;
               cls_lbd   = 8'($urandom_range(12));
            end
            if (!sts_valid && $urandom_range(3) == 0) begin
               sts_valid = 1;
               sts_code  = 4'($urandom_range(15));
            end
            #1 rdy = {sts_ready, cls_ready, div_ready};
            stepCycle();
            if (rdy[0]) div_valid = 0;
            if (rdy[1]) cls_valid = 0;
            if (rdy[2]) sts_valid = 0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Per-core NoC injection scheduler that shares one router injection port between three message sources: divergence requests, learned-clause shares and status reports.
- Filters clause shares by LBD, stamps `src_id` and the virtual channel, and builds `noc_packet_t`.
- Enforces per-VC credit flow control toward the local router.
- Sits between the core's CDCL controller and the mesh router of the swarm grid.

Parameters:
- CORE_ID, 0: value stamped into `src_id` (CORE_ID_W bits).
- CREDITS, 4: initial and maximum credits per VC (1..15).
- LBD_THRESH, 6: clauses with lbd > LBD_THRESH are dropped, not sent.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  grants allowed when high
- div_valid  in  1  divergence request
- div_lit  in  32  signed literal to force on neighbour
- div_ready  out  1  divergence accepted this cycle
- cls_valid  in  1  clause share request
- cls_lit0  in  32  first clause literal
- cls_lit1  in  32  second clause literal
- cls_lbd  in  LBD_W  clause LBD
- cls_ready  out  1  clause accepted (sent or dropped)
- sts_valid  in  1  status request
- sts_code  in  4  status code
- sts_ready  out  1  status accepted
- credit_ret  in  4  one-hot-or-multi pulse, one bit per VC, returns one credit each
- pkt_valid  out  1  packet valid, one-cycle pulse
- pkt_out  out  $bits(noc_packet_t)  injected packet
- drop_cnt  out  16  saturating count of LBD-dropped clauses
- credit_err  out  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- Reset (async, rst_n=0):
  - pkt_valid=0, pkt_out=0, drop_cnt=0, credit_err=0.
  - All VC credit counters = CREDITS; RR pointer = DIVERGE.
  - Reset mid-operation discards any registered packet.
- Class-to-VC map: DIVERGE→VC0, CLAUSE→VC1, STATUS→VC2. VC3 is unused; its credit_ret bit is ignored.
- Eligibility (combinational, cycle t):
  - DIV eligible = div_valid & cred[0]>0.
  - CLS eligible = cls_valid & cls_lbd<=LBD_THRESH & cred[1]>0.
  - STS eligible = sts_valid & cred[2]>0.
- Arbitration: round-robin over eligible classes in order DIV→CLS→STS, starting from the RR pointer. At most one grant per cycle, only when enable=1.
  - After a grant, the pointer moves to the class following the winner.
  - With no grant, the pointer holds.
- ready outputs are combinational in cycle t.
  - div_ready / sts_ready = granted.
  - cls_ready = granted OR drop.
- Drop: cls_valid & cls_lbd>LBD_THRESH & enable.
  - Drop does not use the grant slot; it may coincide with a DIV or STS grant in the same cycle.
  - drop_cnt += 1, saturating at 0xFFFF.
  - Dropped clauses need no credit.
- Packet register (latency 1): a grant in cycle t gives pkt_valid=1 at t+1 with pkt_out registered.
  - pkt_valid=0 in any cycle following a no-grant cycle.
  - Back-to-back grants give consecutive pkt_valid pulses.
- Packet fields:
  - DIV: msg_type=MSG_DIVERGE, payload={32'b0,div_lit}, quality_metric=0.
  - CLS: msg_type=MSG_CLAUSE, payload={cls_lit1,cls_lit0}, quality_metric=cls_lbd.
  - STS: msg_type=MSG_STATUS, payload={60'b0,sts_code}, quality_metric=0.
  - All classes: src_id=CORE_ID, virtual_channel=mapped VC.
- Credit counters: width 4.
  - A grant decrements that VC's counter at edge t.
  - credit_ret[v] increments it.
  - Grant and return on the same VC in the same cycle leave the counter unchanged.
  - A return while the counter is at CREDITS with no same-cycle grant leaves the counter at CREDITS and sets credit_err (cleared only by reset).
  - A counter at 0 makes its class ineligible; the pointer skips it.
- enable=0: no grants, no drops, all ready=0. A packet already registered is still emitted at t+1. Credit returns are still counted.
- Requesters must hold valid and data stable until ready. The block samples only on ready.

Decomposition:
- satswarmv2_pkg gets:
  - typedef enum msg_class_t {CLS_DIV, CLS_CLAUSE, CLS_STATUS}.
  - localparams VC_DIVERGE=0, VC_CLAUSE=1, VC_STATUS=2.
  - typedef logic [3:0] status_code_t.
- Reuse noc_packet_t and msg_type_t from the package.
- One sub-module: rr_arbiter3, a 3-way round-robin arbiter with eligible mask in, one-hot grant out, and pointer state.
- Credit counters and packet formatting stay in the top module.

Test Plan:
- Reset with no traffic. Single div_valid, div_lit=-5 → div_ready at t, next cycle pkt_valid=1 with MSG_DIVERGE, payload[31:0]=32'hFFFFFFFB, src_id=CORE_ID, vc=0; cred[0]=3.
- All three valid continuously, no credit_ret (CREDITS=4) → grant order DIV,CLS,STS repeating. After 12 packets all ready=0 and pkt_valid stays 0 until credit_ret=4'b0010, then exactly one CLS packet.
- cls_lbd=9 and div_valid together, enable=1 → cls_ready=1 and div_ready=1 same cycle; one DIV packet; drop_cnt=1; cred[1] unchanged.
- cls_lbd=6 (equal to threshold) → sent with quality_metric=6 and payload {lit1,lit0}.
- VC0 at 0 credits with grant-pending div plus credit_ret[0] pulse → grant the following cycle. Separately, a same-cycle grant and return on VC2 leaves cred[2] unchanged. credit_ret[0] at full credits → credit_err=1, sticky.
- enable dropped the cycle after a grant → that packet still appears, no further grants. Asserting rst_n=0 during pkt_valid clears pkt_valid immediately and restores all credits to 4.
